// File: rtl/cfu_queue_pkg.sv
// cfu_queue_pkg: shared widths, command entry type and default queue depth
package cfu_queue_pkg;
  localparam int FUNC_ID_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH_DEF = 4;
  typedef struct packed {
    logic [FUNC_ID_W-1:0] function_id;
    logic [DATA_W-1:0]    inputs_0;
    logic [DATA_W-1:0]    inputs_1;
  } cmd_t;
endpackage

// File: rtl/cfu_cmd_fifo.sv
// cfu_cmd_fifo: in-order command storage with occupancy count
// Only pointers and count are reset; the storage array is left unreset.
module cfu_cmd_fifo
  import cfu_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  cmd_t        i_data,
  input  logic        i_pop,
  output cmd_t        o_head,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);
  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  // Power-of-two depth lets the pointers wrap by natural overflow
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/cfu_cmd_queue.sv
// cfu_cmd_queue: buffers CPU commands in front of a Cfu and holds one result for the CPU
module cfu_cmd_queue
  import cfu_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [FUNC_ID_W-1:0]     cmd_payload_function_id,
  input  logic [DATA_W-1:0]        cmd_payload_inputs_0,
  input  logic [DATA_W-1:0]        cmd_payload_inputs_1,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_payload_outputs_0,
  output logic                     cfu_cmd_valid,
  input  logic                     cfu_cmd_ready,
  output logic [FUNC_ID_W-1:0]     cfu_cmd_payload_function_id,
  output logic [DATA_W-1:0]        cfu_cmd_payload_inputs_0,
  output logic [DATA_W-1:0]        cfu_cmd_payload_inputs_1,
  input  logic                     cfu_rsp_valid,
  output logic                     cfu_rsp_ready,
  input  logic [DATA_W-1:0]        cfu_rsp_payload_outputs_0,
  output logic [$clog2(DEPTH):0]   count
);
  cmd_t              w_cmd;
  cmd_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_cap;
  logic              r_full;
  logic [DATA_W-1:0] r_rsp;
  assign w_cmd = '{cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};
  cfu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (cmd_valid),
    .i_data  (w_cmd),
    .i_pop   (cfu_cmd_ready),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );
  assign cmd_ready                   = !w_full;
  assign cfu_cmd_valid               = !w_empty;
  assign cfu_cmd_payload_function_id = w_head.function_id;
  assign cfu_cmd_payload_inputs_0    = w_head.inputs_0;
  assign cfu_cmd_payload_inputs_1    = w_head.inputs_1;
  // A draining holding register can take a new result in the same cycle
  assign cfu_rsp_ready         = !r_full || rsp_ready;
  assign w_cap                 = cfu_rsp_valid && cfu_rsp_ready;
  assign rsp_valid             = r_full;
  assign rsp_payload_outputs_0 = r_rsp;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_rsp  <= '0;
    end else begin
      r_full <= w_cap ? 1'b1 : (rsp_ready ? 1'b0 : r_full);
      r_rsp  <= w_cap ? cfu_rsp_payload_outputs_0 : r_rsp;
    end
  end
endmodule

// File: tb/tb_cfu_cmd_queue.sv
// tb_cfu_cmd_queue: scoreboard bench with a combinational Cfu model behind the queue
module tb_cfu_cmd_queue;
  logic        clk = 0;
  logic        reset = 0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id = '0;
  logic [31:0] cmd_payload_inputs_0 = '0;
  logic [31:0] cmd_payload_inputs_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1;
  logic [31:0] rsp_payload_outputs_0;
  logic        cfu_cmd_valid;
  logic        cfu_cmd_ready;
  logic [9:0]  cfu_cmd_payload_function_id;
  logic [31:0] cfu_cmd_payload_inputs_0;
  logic [31:0] cfu_cmd_payload_inputs_1;
  logic        cfu_rsp_valid;
  logic        cfu_rsp_ready;
  logic [31:0] cfu_rsp_payload_outputs_0;
  logic [2:0]  count;
  logic        stall = 0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];

  function automatic logic [31:0] cfu_f(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a - b;
    if (f == 0)
      r = 32'(a[7:0]) + 32'(a[15:8]) + 32'(a[23:16]) + 32'(a[31:24]) +
          32'(b[7:0]) + 32'(b[15:8]) + 32'(b[23:16]) + 32'(b[31:24]);
    else if (f == 1)
      r = {a[7:0], a[15:8], a[23:16], a[31:24]};
    else if (f == 2)
      for (int i = 0; i < 32; i++) r[i] = a[31-i];
    return r;
  endfunction

  assign cfu_rsp_valid             = cfu_cmd_valid && !stall;
  assign cfu_cmd_ready             = cfu_rsp_ready && !stall;
  assign cfu_rsp_payload_outputs_0 = cfu_f(cfu_cmd_payload_function_id, cfu_cmd_payload_inputs_0, cfu_cmd_payload_inputs_1);

  cfu_cmd_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .cfu_cmd_valid(cfu_cmd_valid), .cfu_cmd_ready(cfu_cmd_ready),
    .cfu_cmd_payload_function_id(cfu_cmd_payload_function_id),
    .cfu_cmd_payload_inputs_0(cfu_cmd_payload_inputs_0),
    .cfu_cmd_payload_inputs_1(cfu_cmd_payload_inputs_1),
    .cfu_rsp_valid(cfu_rsp_valid), .cfu_rsp_ready(cfu_rsp_ready),
    .cfu_rsp_payload_outputs_0(cfu_rsp_payload_outputs_0),
    .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (reset && rsp_valid && rsp_ready) begin
      got_q.push_back(rsp_payload_outputs_0);
      got_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    cmd_payload_function_id = f;
    cmd_payload_inputs_0 = a;
    cmd_payload_inputs_1 = b;
    cmd_valid = 1;
    while (!cmd_ready && t < 100) begin step(1); t++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: cmd_ready=%0b after %0d cycles, need 1", cmd_ready, t);
      cmd_valid = 0;
      return;
    end
    step(1);
    cmd_valid = 0;
    exp_q.push_back(cfu_f(f, a, b));
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got_q.size() < n && t < 200) begin step(1); t++; end
  endtask

  task automatic drain_check(input string name);
    int n = exp_q.size();
    wait_got(n);
    step(3);
    tests++;
    if (got_q.size() != n) begin
      fails++;
      $display("FAIL %s_count: got %0d responses, need %0d", name, got_q.size(), n);
    end
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s_data[%0d]: got %h, need %h", name, i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_reset();
    step(2);
    tests++;
    if (count !== 0 || rsp_valid !== 0 || cfu_cmd_valid !== 0) begin
      fails++;
      $display("FAIL reset_during: count=%0d rsp_valid=%b cfu_cmd_valid=%b, need 0/0/0", count, rsp_valid, cfu_cmd_valid);
    end
    reset = 1;
    step(1);
    tests++;
    if ({cmd_ready, cfu_cmd_valid, rsp_valid, cfu_rsp_ready} !== 4'b1001 || count !== 0) begin
      fails++;
      $display("FAIL reset_after: rdy/cv/rv/crr=%b count=%0d, need 1001 count=0",
               {cmd_ready, cfu_cmd_valid, rsp_valid, cfu_rsp_ready}, count);
    end
  endtask

  task automatic test_single();
    rsp_ready = 1;
    send(10'd0, 32'h01020304, 32'h10203040);
    tests++;
    if (count !== 1 || cfu_cmd_valid !== 1 || rsp_valid !== 0) begin
      fails++;
      $display("FAIL single_n1: count=%0d cfu_cmd_valid=%b rsp_valid=%b, need 1/1/0", count, cfu_cmd_valid, rsp_valid);
    end
    step(1);
    tests++;
    if (rsp_valid !== 1 || rsp_payload_outputs_0 !== 32'h000000AA || count !== 0) begin
      fails++;
      $display("FAIL single_n2: rsp_valid=%b data=%h count=%0d, need 1/000000aa/0", rsp_valid, rsp_payload_outputs_0, count);
    end
    drain_check("single");
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1;
    send(10'd1, 32'h11223344, 32'h0);
    send(10'd1, 32'hAABBCCDD, 32'h0);
    wait_got(2);
    tests++;
    if (got_q.size() < 2 || got_q[0] !== 32'h44332211 || got_q[1] !== 32'hDDCCBBAA || got_cyc[1] - got_cyc[0] != 1) begin
      fails++;
      $display("FAIL b2b: got %0d responses %h %h gap %0d, need 44332211 ddccbbaa gap 1",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 32'hx, got_q.size() > 1 ? got_q[1] : 32'hx,
               got_q.size() > 1 ? got_cyc[1] - got_cyc[0] : -1);
    end
    drain_check("b2b");
  endtask

  task automatic test_full();
    logic [31:0] first;
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) send(10'd3, 32'h100 * i + 32'h7, 32'(i));
    first = exp_q[0];
    tests++;
    if (count !== 4 || cmd_ready !== 0 || rsp_valid !== 1) begin
      fails++;
      $display("FAIL full_state: count=%0d cmd_ready=%b rsp_valid=%b, need 4/0/1", count, cmd_ready, rsp_valid);
    end
    cmd_payload_function_id = 10'd3;
    cmd_payload_inputs_0 = 32'hDEAD;
    cmd_payload_inputs_1 = 32'h1;
    cmd_valid = 1;
    step(3);
    cmd_valid = 0;
    tests++;
    if (count !== 4 || rsp_payload_outputs_0 !== first || cfu_cmd_payload_inputs_0 !== 32'h107) begin
      fails++;
      $display("FAIL full_hold: count=%0d rsp=%h head_in0=%h, need 4/%h/00000107", count, rsp_payload_outputs_0, cfu_cmd_payload_inputs_0, first);
    end
    rsp_ready = 1;
    drain_check("full");
    tests++;
    if (count !== 0 || rsp_valid !== 0) begin
      fails++;
      $display("FAIL full_empty: count=%0d rsp_valid=%b, need 0/0", count, rsp_valid);
    end
  endtask

  task automatic test_wrap();
    rsp_ready = 1;
    stall = 1;
    for (int i = 0; i < 3; i++) send(10'd3, 32'h5000 + 32'(i), 32'h3);
    tests++;
    if (count !== 3) begin
      fails++;
      $display("FAIL wrap_fill: count=%0d, need 3", count);
    end
    stall = 0;
    for (int i = 3; i < 9; i++) begin
      send(10'd2, 32'h5000 + 32'(i * 3), 32'h0);
      tests++;
      if (count !== 3) begin
        fails++;
        $display("FAIL wrap_pushpop[%0d]: count=%0d, need 3", i, count);
      end
    end
    drain_check("wrap");
  endtask

  task automatic test_reset_mid();
    rsp_ready = 0;
    for (int i = 0; i < 4; i++) send(10'd1, 32'hC0DE0000 + 32'(i), 32'h0);
    tests++;
    if (count !== 3 || rsp_valid !== 1) begin
      fails++;
      $display("FAIL mid_pre: count=%0d rsp_valid=%b, need 3/1", count, rsp_valid);
    end
    reset = 0;
    #1;
    tests++;
    if (count !== 0 || rsp_valid !== 0 || cfu_cmd_valid !== 0) begin
      fails++;
      $display("FAIL mid_async: count=%0d rsp_valid=%b cfu_cmd_valid=%b, need 0/0/0", count, rsp_valid, cfu_cmd_valid);
    end
    exp_q.delete();
    step(1);
    reset = 1;
    rsp_ready = 1;
    step(5);
    tests++;
    if (got_q.size() != 0) begin
      fails++;
      $display("FAIL mid_discard: got %0d responses, need 0", got_q.size());
    end
    send(10'd2, 32'h00000001, 32'h0);
    wait_got(1);
    tests++;
    if (got_q.size() < 1 || got_q[0] !== 32'h80000000) begin
      fails++;
      $display("FAIL mid_after: got %0d responses first %h, need 80000000", got_q.size(), got_q.size() > 0 ? got_q[0] : 32'hx);
    end
    drain_check("mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
